// File: rtl/eth_mgmt_csr_bridge_pkg.sv
// Shared definitions for the MMIO-to-MAC-management bridge: CSR map, STATUS
// bit layout, the latched command format and the FSM states.
package eth_mgmt_pkg;

    localparam logic [3:0] CSR_DFH     = 4'd0;
    localparam logic [3:0] CSR_ID_L    = 4'd1;
    localparam logic [3:0] CSR_ID_H    = 4'd2;
    localparam logic [3:0] CSR_INIT    = 4'd3;
    localparam logic [3:0] CSR_CMD     = 4'd4;
    localparam logic [3:0] CSR_WDATA   = 4'd5;
    localparam logic [3:0] CSR_RDATA   = 4'd6;
    localparam logic [3:0] CSR_STATUS  = 4'd7;
    localparam logic [3:0] CSR_SCRATCH = 4'd8;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_BADCH   = 3;
    localparam int ST_OVERRUN = 4;

    localparam logic [63:0] DFH_VALUE = 64'h1000000000000001;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  ch;
        logic        is_wr;
    } t_mgmt_cmd;

    typedef enum logic {
        IDLE,
        ISSUE
    } t_state;

    // CMD layout: [15:0] address, [19:16] channel, [20] write
    function automatic t_mgmt_cmd decodeCmd(input logic [20:0] w);
        t_mgmt_cmd c;
        c.addr  = w[15:0];
        c.ch    = w[19:16];
        c.is_wr = w[20];
        return c;
    endfunction

endpackage

// File: rtl/eth_mgmt_csr_bridge_if.sv
// MMIO request/response and per-channel Avalon-MM management signals.
// The bridge uses the slave view; the host/MAC environment uses the master view.
interface eth_mgmt_csr_bridge_if #(
    parameter int NUM_CH      = 4,
    parameter int MGMT_ADDR_W = 16,
    parameter int MGMT_DATA_W = 32
);
    logic                          mmio_wr_en;
    logic                          mmio_rd_en;
    logic [3:0]                    mmio_addr;
    logic [63:0]                   mmio_wdata;
    logic [8:0]                    mmio_tid;
    logic                          mmio_rd_valid;
    logic [8:0]                    mmio_rd_tid;
    logic [63:0]                   mmio_rd_data;
    logic [MGMT_ADDR_W-1:0]        mgmt_address;
    logic [MGMT_DATA_W-1:0]        mgmt_writedata;
    logic [NUM_CH-1:0]             mgmt_write;
    logic [NUM_CH-1:0]             mgmt_read;
    logic [NUM_CH*MGMT_DATA_W-1:0] mgmt_readdata;
    logic [NUM_CH-1:0]             mgmt_waitrequest;
    logic                          init_start;
    logic                          init_done;

    modport slave (
        input  mmio_wr_en, mmio_rd_en, mmio_addr, mmio_wdata, mmio_tid,
               mgmt_readdata, mgmt_waitrequest, init_done,
        output mmio_rd_valid, mmio_rd_tid, mmio_rd_data,
               mgmt_address, mgmt_writedata, mgmt_write, mgmt_read, init_start
    );

    modport master (
        output mmio_wr_en, mmio_rd_en, mmio_addr, mmio_wdata, mmio_tid,
               mgmt_readdata, mgmt_waitrequest, init_done,
        input  mmio_rd_valid, mmio_rd_tid, mmio_rd_data,
               mgmt_address, mgmt_writedata, mgmt_write, mgmt_read, init_start
    );
endinterface

// File: rtl/eth_mgmt_channel_mux.sv
// Steers the single registered request onto the selected channel and returns
// that channel's readdata/waitrequest. Purely combinational.
module eth_mgmt_channel_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
) (
    input  logic                     reqWr_i,
    input  logic                     reqRd_i,
    input  logic [3:0]               ch_i,
    input  logic [NUM_CH*DATA_W-1:0] readdata_i,
    input  logic [NUM_CH-1:0]        waitrequest_i,
    output logic [NUM_CH-1:0]        write_o,
    output logic [NUM_CH-1:0]        read_o,
    output logic [DATA_W-1:0]        readdata_o,
    output logic                     waitrequest_o
);

    // An unmatched channel reads as stalled so it can never complete an op
    always_comb begin
        write_o       = '0;
        read_o        = '0;
        readdata_o    = '0;
        waitrequest_o = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(ch_i) == c) begin
                write_o[c]    = reqWr_i;
                read_o[c]     = reqRd_i;
                readdata_o    = readdata_i[c*DATA_W +: DATA_W];
                waitrequest_o = waitrequest_i[c];
            end
        end
    end

endmodule

// File: rtl/eth_mgmt_csr_bridge.sv
// MMIO CSR block that launches single Avalon-MM management operations on one
// of NUM_CH MAC channels, with timeout, sticky error status and an op counter.
module eth_mgmt_csr_bridge
    import eth_mgmt_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          MGMT_ADDR_W = 16,
    parameter int          MGMT_DATA_W = 32,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [63:0] AFU_ID_L    = 64'hB3C151A1B62ED6C2,
    parameter logic [63:0] AFU_ID_H    = 64'h26B40788034B4389
) (
    input logic                 clk,
    input logic                 reset,
    eth_mgmt_csr_bridge_if.slave bus
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    t_state                 state_q;
    t_mgmt_cmd              op_q;
    t_mgmt_cmd              newCmd;
    logic [MGMT_DATA_W-1:0] opWdata_q;
    logic [MGMT_DATA_W-1:0] rdata_q;
    logic [MGMT_DATA_W-1:0] selReaddata;
    logic                   reqWr_q;
    logic                   reqRd_q;
    logic                   selWait;
    logic [TMR_W-1:0]       timer_q;
    logic [31:0]            opCount_q;
    logic [63:0]            cmdCsr_q;
    logic [63:0]            wdataCsr_q;
    logic [63:0]            scratch_q;
    logic                   initCsr_q;
    logic                   initDone_q;
    logic [4:1]             sticky_q;
    logic [4:1]             sticky_d;
    logic                   rdPend_q;
    logic [3:0]             rdIdx_q;
    logic [8:0]             rdTidPend_q;
    logic                   rdValid_q;
    logic [8:0]             rdTid_q;
    logic [63:0]            rdData_q;
    logic [63:0]            rdData_d;

    logic cmdWr, statusWr, chOk, busy, launch, badCh, opDone, opTimeout;

    assign newCmd    = decodeCmd(bus.mmio_wdata[20:0]);
    assign cmdWr     = bus.mmio_wr_en && (bus.mmio_addr == CSR_CMD);
    assign statusWr  = bus.mmio_wr_en && (bus.mmio_addr == CSR_STATUS);
    assign chOk      = int'(newCmd.ch) < NUM_CH;
    assign busy      = (state_q == ISSUE);
    assign launch    = !busy && cmdWr && chOk;
    assign badCh     = !busy && cmdWr && !chOk;
    assign opDone    = busy && !selWait;
    assign opTimeout = busy && selWait && (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            opWdata_q <= '0;
            reqWr_q   <= 1'b0;
            reqRd_q   <= 1'b0;
            timer_q   <= '0;
            rdata_q   <= '0;
            opCount_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        op_q      <= newCmd;
                        opWdata_q <= wdataCsr_q[MGMT_DATA_W-1:0];
                        reqWr_q   <= newCmd.is_wr;
                        reqRd_q   <= !newCmd.is_wr;
                        timer_q   <= '0;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (opDone) begin
                        reqWr_q   <= 1'b0;
                        reqRd_q   <= 1'b0;
                        if (reqRd_q) rdata_q <= selReaddata;
                        opCount_q <= opCount_q + 32'd1;
                        state_q   <= IDLE;
                    end else if (opTimeout) begin
                        reqWr_q <= 1'b0;
                        reqRd_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // W1C is applied first so a same-cycle hardware event always survives
    always_comb begin
        sticky_d = sticky_q;
        if (statusWr) sticky_d = sticky_d & ~bus.mmio_wdata[4:1];
        if (launch) sticky_d[ST_DONE] = 1'b0;
        if (opDone || opTimeout || badCh) sticky_d[ST_DONE] = 1'b1;
        if (opTimeout) sticky_d[ST_TIMEOUT] = 1'b1;
        if (badCh) sticky_d[ST_BADCH] = 1'b1;
        if (busy && cmdWr) sticky_d[ST_OVERRUN] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmdCsr_q   <= '0;
            wdataCsr_q <= '0;
            scratch_q  <= '0;
            initCsr_q  <= 1'b0;
            initDone_q <= 1'b0;
            sticky_q   <= '0;
        end else begin
            initDone_q <= bus.init_done;
            sticky_q   <= sticky_d;
            if (cmdWr && !busy) cmdCsr_q <= bus.mmio_wdata;
            if (bus.mmio_wr_en && bus.mmio_addr == CSR_WDATA) wdataCsr_q <= bus.mmio_wdata;
            if (bus.mmio_wr_en && bus.mmio_addr == CSR_SCRATCH) scratch_q <= bus.mmio_wdata;
            if (bus.mmio_wr_en && bus.mmio_addr == CSR_INIT) initCsr_q <= bus.mmio_wdata[0];
        end
    end

    always_comb begin
        rdData_d = '0;
        case (rdIdx_q)
            CSR_DFH:     rdData_d = DFH_VALUE;
            CSR_ID_L:    rdData_d = AFU_ID_L;
            CSR_ID_H:    rdData_d = AFU_ID_H;
            CSR_INIT:    rdData_d = {62'b0, initDone_q, initCsr_q};
            CSR_CMD:     rdData_d = cmdCsr_q;
            CSR_WDATA:   rdData_d = wdataCsr_q;
            CSR_RDATA:   rdData_d = {{(64-MGMT_DATA_W){1'b0}}, rdata_q};
            CSR_STATUS:  rdData_d = {opCount_q, 27'b0, sticky_q, busy};
            CSR_SCRATCH: rdData_d = scratch_q;
            default:     rdData_d = '0;
        endcase
    end

    // First stage holds the index so the CSR contents are sampled one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPend_q    <= 1'b0;
            rdIdx_q     <= '0;
            rdTidPend_q <= '0;
            rdValid_q   <= 1'b0;
            rdTid_q     <= '0;
            rdData_q    <= '0;
        end else begin
            rdPend_q    <= bus.mmio_rd_en;
            rdIdx_q     <= bus.mmio_addr;
            rdTidPend_q <= bus.mmio_tid;
            rdValid_q   <= rdPend_q;
            rdTid_q     <= rdTidPend_q;
            rdData_q    <= rdData_d;
        end
    end

    eth_mgmt_channel_mux #(
        .NUM_CH (NUM_CH),
        .DATA_W (MGMT_DATA_W)
    ) u_mux (
        .reqWr_i       (reqWr_q),
        .reqRd_i       (reqRd_q),
        .ch_i          (op_q.ch),
        .readdata_i    (bus.mgmt_readdata),
        .waitrequest_i (bus.mgmt_waitrequest),
        .write_o       (bus.mgmt_write),
        .read_o        (bus.mgmt_read),
        .readdata_o    (selReaddata),
        .waitrequest_o (selWait)
    );

    assign bus.mmio_rd_valid  = rdValid_q;
    assign bus.mmio_rd_tid    = rdTid_q;
    assign bus.mmio_rd_data   = rdData_q;
    assign bus.mgmt_address   = MGMT_ADDR_W'(op_q.addr);
    assign bus.mgmt_writedata = opWdata_q;
    assign bus.init_start     = initCsr_q;

endmodule

// File: tb/tb_eth_mgmt_csr_bridge.sv
// Scoreboard bench for eth_mgmt_csr_bridge: MMIO reads push expectations,
// a negedge monitor pops and compares; management-side pins are checked inline.
module tb_eth_mgmt_csr_bridge;
    import eth_mgmt_pkg::*;

    localparam int NUM_CH = 4;
    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int TO     = 8;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          cyc;
    } t_exp;

    logic       clk = 1'b0;
    logic       reset;
    int         checks = 0;
    int         errors = 0;
    int         cycleCnt = 0;
    logic [8:0] nextTid = 9'h040;
    t_exp       expQ[$];
    t_exp       monItem;

    eth_mgmt_csr_bridge_if #(.NUM_CH(NUM_CH), .MGMT_ADDR_W(AW), .MGMT_DATA_W(DW)) bus ();

    eth_mgmt_csr_bridge #(
        .NUM_CH      (NUM_CH),
        .MGMT_ADDR_W (AW),
        .MGMT_DATA_W (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every rd_valid must match the oldest outstanding read
    always @(negedge clk) begin
        if (bus.mmio_rd_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_unexpected: got response tid %h, expected none", bus.mmio_rd_tid);
            end else begin
                monItem = expQ.pop_front();
                checkOutput("rd_tid", 64'(bus.mmio_rd_tid), 64'(monItem.tid));
                checkOutput("rd_data", bus.mmio_rd_data, monItem.data);
                checkOutput("rd_latency", 64'(cycleCnt - monItem.cyc), 64'd2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setWr(input logic [3:0] idx, input logic [63:0] data);
        bus.mmio_wr_en = 1'b1;
        bus.mmio_addr  = idx;
        bus.mmio_wdata = data;
    endtask

    task automatic clrWr();
        bus.mmio_wr_en = 1'b0;
    endtask

    task automatic mmioWrite(input logic [3:0] idx, input logic [63:0] data);
        setWr(idx, data);
        tick();
        clrWr();
    endtask

    task automatic mmioRead(input logic [3:0] idx, input logic [63:0] exp);
        t_exp e;
        e.tid  = nextTid;
        e.data = exp;
        e.cyc  = cycleCnt;
        expQ.push_back(e);
        bus.mmio_rd_en = 1'b1;
        bus.mmio_addr  = idx;
        bus.mmio_tid   = nextTid;
        nextTid        = nextTid + 9'd7;
        tick();
        bus.mmio_rd_en = 1'b0;
    endtask

    task automatic applyStimulus();
        reset                 = 1'b1;
        bus.mmio_wr_en        = 1'b0;
        bus.mmio_rd_en        = 1'b0;
        bus.mmio_addr         = '0;
        bus.mmio_wdata        = '0;
        bus.mmio_tid          = '0;
        bus.init_done         = 1'b0;
        bus.mgmt_waitrequest  = '1;
        bus.mgmt_readdata     = {32'hCAFE0003, 32'hDEADBEEF, 32'h0BAD0001, 32'h0BAD0000};

        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_rd_valid", 64'(bus.mmio_rd_valid), 64'd0);
        checkOutput("reset_mgmt_req", 64'({bus.mgmt_write, bus.mgmt_read}), 64'd0);
        checkOutput("reset_init_start", 64'(bus.init_start), 64'd0);
        checkOutput("reset_addr_data", {16'(bus.mgmt_address), 32'(bus.mgmt_writedata)}, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        mmioRead(CSR_STATUS, 64'd0);
        mmioRead(CSR_RDATA, 64'd0);

        // SCRATCH written in the same cycle it is read, then pipelined reads
        setWr(CSR_SCRATCH, 64'hA5A5A5A5A5A5A5A5);
        mmioRead(CSR_SCRATCH, 64'hA5A5A5A5A5A5A5A5);
        clrWr();
        mmioRead(CSR_DFH, 64'h1000000000000001);
        mmioRead(4'hF, 64'd0);
        mmioRead(CSR_ID_L, 64'hB3C151A1B62ED6C2);
        mmioRead(CSR_ID_H, 64'h26B40788034B4389);

        bus.init_done = 1'b1;
        mmioWrite(CSR_INIT, 64'd1);
        @(negedge clk);
        checkOutput("init_start_set", 64'(bus.init_start), 64'd1);
        tick();
        mmioRead(CSR_INIT, 64'd3);
        mmioWrite(CSR_INIT, 64'd0);
        @(negedge clk);
        checkOutput("init_start_clr", 64'(bus.init_start), 64'd0);
        tick();

        // Read channel 2: three stalled cycles, then accepted
        mmioWrite(CSR_CMD, 64'h0000_0000_0002_0010);
        for (int i = 0; i < 4; i++) begin
            bus.mgmt_waitrequest[2] = (i == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            checkOutput("ch2_read_req", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h04);
            checkOutput("ch2_read_addr", 64'(bus.mgmt_address), 64'h0010);
            tick();
        end
        bus.mgmt_waitrequest[2] = 1'b1;
        @(negedge clk);
        checkOutput("ch2_read_drop", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h00);
        tick();
        mmioRead(CSR_RDATA, 64'h0000_0000_DEAD_BEEF);
        mmioRead(CSR_STATUS, 64'h0000_0001_0000_0002);
        mmioRead(CSR_CMD, 64'h0000_0000_0002_0010);

        // Write channel 0 with no stall: exactly one request cycle
        mmioWrite(CSR_WDATA, 64'h1234);
        bus.mgmt_waitrequest[0] = 1'b0;
        mmioWrite(CSR_CMD, 64'h0000_0000_0010_0004);
        @(negedge clk);
        checkOutput("ch0_write_req", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h10);
        checkOutput("ch0_write_addr", 64'(bus.mgmt_address), 64'h0004);
        checkOutput("ch0_write_data", 64'(bus.mgmt_writedata), 64'h1234);
        tick();
        @(negedge clk);
        checkOutput("ch0_write_drop", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h00);
        tick();
        bus.mgmt_waitrequest[0] = 1'b1;
        mmioRead(CSR_STATUS, 64'h0000_0002_0000_0002);

        // Timeout on channel 1
        mmioWrite(CSR_STATUS, 64'h2);
        mmioWrite(CSR_CMD, 64'h0000_0000_0001_0020);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            checkOutput("timeout_req", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h02);
            tick();
        end
        @(negedge clk);
        checkOutput("timeout_drop", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h00);
        tick();
        mmioRead(CSR_STATUS, 64'h0000_0002_0000_0006);
        mmioRead(CSR_RDATA, 64'h0000_0000_DEAD_BEEF);
        mmioWrite(CSR_STATUS, 64'h4);
        mmioRead(CSR_STATUS, 64'h0000_0002_0000_0002);

        // Bad channel: nothing reaches the bus
        mmioWrite(CSR_CMD, 64'h0000_0000_0005_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("badch_no_req", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h00);
            tick();
        end
        mmioRead(CSR_STATUS, 64'h0000_0002_0000_000A);
        mmioWrite(CSR_STATUS, 64'h1E);
        mmioRead(CSR_STATUS, 64'h0000_0002_0000_0000);

        // Overrun, WDATA change in flight, and W1C of done on the exit cycle
        mmioWrite(CSR_WDATA, 64'h5A5A);
        mmioWrite(CSR_CMD, 64'h0000_0000_0013_0030);
        setWr(CSR_CMD, 64'h0000_0000_0010_0099);
        @(negedge clk);
        checkOutput("ovr_req_c1", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h80);
        tick();
        setWr(CSR_WDATA, 64'h7777);
        @(negedge clk);
        checkOutput("ovr_req_c2", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h80);
        checkOutput("ovr_addr", 64'(bus.mgmt_address), 64'h0030);
        tick();
        setWr(CSR_STATUS, 64'h2);
        bus.mgmt_waitrequest[3] = 1'b0;
        @(negedge clk);
        checkOutput("ovr_req_c3", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h80);
        checkOutput("ovr_wdata", 64'(bus.mgmt_writedata), 64'h5A5A);
        tick();
        clrWr();
        bus.mgmt_waitrequest[3] = 1'b1;
        @(negedge clk);
        checkOutput("ovr_drop", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h00);
        tick();
        mmioRead(CSR_STATUS, 64'h0000_0003_0000_0012);
        mmioRead(CSR_CMD, 64'h0000_0000_0013_0030);
        mmioRead(CSR_WDATA, 64'h7777);
        repeat (3) tick();

        // Reset while a read is stalled in ISSUE
        mmioWrite(CSR_CMD, 64'h0000_0000_0001_0040);
        @(negedge clk);
        checkOutput("rst_req_before", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h02);
        tick();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_held", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h02);
        tick();
        @(negedge clk);
        checkOutput("rst_req_drop", 64'({bus.mgmt_write, bus.mgmt_read}), 64'h00);
        checkOutput("rst_addr", 64'(bus.mgmt_address), 64'h0);
        tick();
        reset = 1'b0;
        tick();
        mmioRead(CSR_STATUS, 64'd0);
        mmioRead(CSR_RDATA, 64'd0);
        mmioRead(CSR_SCRATCH, 64'd0);
        mmioRead(CSR_CMD, 64'd0);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) tick();
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rd_drain: got %0d outstanding reads, expected 0", expQ.size());
        end
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/eth_mgmt_csr_bridge.md
Name: eth_mgmt_csr_bridge

Overview:
- Parametrised MMIO-to-MAC-management bridge. Replaces the single-channel, level-triggered control-address scheme with per-channel Avalon-MM management masters.
- Handshake is waitrequest-based, with a timeout, sticky error status and a completed-operation counter.
- Sits between the CCI-P MMIO decode (flattened fields) and NUM_CH Ethernet MAC/PHY management ports. Everything runs in one clock domain.

Parameters:
- NUM_CH, 4, number of MAC management channels (1..16)
- MGMT_ADDR_W, 16, management address width
- MGMT_DATA_W, 32, management data width (at most 32)
- TIMEOUT_CYC, 1024, cycles in ISSUE before abort (at least 2)
- AFU_ID_L, 64'hB3C151A1B62ED6C2, ID low word
- AFU_ID_H, 64'h26B40788034B4389, ID high word

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- mmio_wr_en  in  1  MMIO write strobe
- mmio_rd_en  in  1  MMIO read strobe
- mmio_addr  in  4  8-byte CSR index
- mmio_wdata  in  64  write data
- mmio_tid  in  9  read transaction id
- mmio_rd_valid  out  1  read response valid
- mmio_rd_tid  out  9  echoed tid
- mmio_rd_data  out  64  read data
- mgmt_address  out  MGMT_ADDR_W  shared address
- mgmt_writedata  out  MGMT_DATA_W  shared write data
- mgmt_write  out  NUM_CH  per-channel write request
- mgmt_read  out  NUM_CH  per-channel read request
- mgmt_readdata  in  NUM_CH*MGMT_DATA_W  channel c occupies bits [c*W +: W]
- mgmt_waitrequest  in  NUM_CH  per-channel stall
- init_start  out  1  PHY init request (INIT[0])
- init_done  in  1  PHY init complete

Behaviour:
- CSR map by index:
  - 0 DFH, reads 64'h1000000000000001
  - 1 ID_L
  - 2 ID_H
  - 3 INIT: [0] RW; [1] RO = init_done, registered one cycle
  - 4 CMD: [15:0] address, [19:16] channel, [20] 1=write 0=read; RW; a write launches an operation
  - 5 WDATA: RW
  - 6 RDATA: RO, zero-extended
  - 7 STATUS: [0] busy, [1] done, [2] err_timeout, [3] err_badch, [4] err_overrun, [63:32] op_count. Bits [4:1] are sticky and write-1-to-clear.
  - 8 SCRATCH: RW
  - any other index reads 0; writes to it are ignored.
- Read path:
  - Fixed 2-cycle latency: rd_en at cycle T gives rd_valid, tid and data at T+2.
  - Data is sampled at T+1, so a CSR write at T is visible.
  - Back-to-back reads are pipelined.
- Reset values:
  - mmio_rd_valid=0, mgmt_write=0, mgmt_read=0, init_start=0.
  - All CSRs 0; state IDLE; op_count=0.
  - mgmt_address and mgmt_writedata are 0.
  - The read-data and tid pipeline is reset too.
- FSM IDLE:
  - CMD write with channel < NUM_CH: latch address, channel, direction and WDATA; set busy=1, done=0; go to ISSUE next cycle.
  - CMD write with channel >= NUM_CH: no bus activity; set err_badch=1 and done=1; op_count unchanged.
- FSM ISSUE:
  - Exactly one bit of mgmt_read or mgmt_write is set, for the latched channel. Address and data stay stable.
  - Exit cycle is the first cycle where mgmt_waitrequest[ch]==0 while the request is asserted.
  - On exit: request drops the next cycle; for reads, RDATA captures the channel's readdata in that same exit cycle.
  - Then done=1, busy=0, op_count+1 (wraps at 2^32), back to IDLE.
  - Minimum op latency is 2 cycles: CMD write, then one ISSUE cycle.
- Timeout:
  - A counter clears on ISSUE entry.
  - When it reaches TIMEOUT_CYC-1 with waitrequest still high: drop the request, set err_timeout=1 and done=1, leave RDATA unchanged, op_count unchanged, go to IDLE.
- CMD write while busy: ignored apart from setting err_overrun=1. The CMD register does not update.
- Same-cycle STATUS write-1-to-clear and a hardware set: the set wins.
- WDATA write during ISSUE: no effect on the op in flight.
- reset asserted mid-ISSUE: request drops at the next edge. No completion is reported.

Decomposition:
- Package eth_mgmt_pkg:
  - CSR index localparams
  - STATUS bit positions
  - t_mgmt_cmd struct {addr, ch, is_wr}
  - FSM state enum {IDLE, ISSUE}
- Sub-module eth_mgmt_channel_mux: demultiplexes the request onto channel ch and muxes the readdata/waitrequest back. Purely combinational; instantiated once.

Test Plan:
- Read channel 2: WDATA untouched; CMD=0x0002_0010; mgmt_waitrequest[2] high for 3 cycles, then low with readdata 0xDEADBEEF → mgmt_read=4'b0100 for 4 cycles; RDATA=0xDEADBEEF; STATUS[1]=1, op_count=1.
- Write channel 0: WDATA=0x1234, then CMD=0x0010_0004 with waitrequest low → mgmt_write[0] for exactly 1 cycle, address 0x0004, data 0x1234; done=1.
- Timeout (TIMEOUT_CYC=8, waitrequest stuck high): request asserted for 8 cycles → err_timeout=1, busy=0, op_count unchanged. Then writing STATUS=0x4 clears bit 2.
- Bad channel: CMD channel=5 with NUM_CH=4 → no mgmt_read or mgmt_write ever asserts; err_badch=1.
- Overrun and reset: second CMD during ISSUE → err_overrun=1 and the original op completes unchanged. Reset mid-ISSUE → all requests 0 next cycle; STATUS reads 0.
- MMIO basics: write SCRATCH 0xA5A5..., then reads of indices 8, 0 and 0xF on consecutive cycles → rd_valid at T+2..T+4 with correct tids; data A5A5.., 0x1000000000000001, 0.
